wb_grf: RTL and testbench
=========================

# wb_grf

Writeback stage plus general register file for the five-stage MIPS pipeline. Consumes the W-stage bundle (`W_PC`, `W_Instr`, `W_ALUAns`, `W_DMRD`) registered out of the M/W pipeline register. Decodes the destination register and write-data source, extracts sub-word loads, and commits to a 32×32 register file. Serves the D-stage read ports with same-cycle write bypass and exports the W-stage write tuple to the forwarding unit, together with a retired-instruction counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: reference only; must not be used by the logic. The retire counter ignores the PC value.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; registers clear at a rising edge sampled with `reset==0`.
- `W_PC`  in  32  PC of the W-stage instruction.
- `W_Instr`  in  32  W-stage instruction word; 32'h0 is a bubble.
- `W_ALUAns`  in  32  ALU result; also the load address.
- `W_DMRD`  in  32  raw aligned data-memory word.
- `D_A1`, `D_A2`  in  5  D-stage read addresses.
- `D_RD1`, `D_RD2`  out  32  read data, bypassed.
- `W_WE`  out  1  W-stage write is effective (`W_WA != 0`).
- `W_WA`  out  5  W-stage destination register.
- `W_WD`  out  32  W-stage write data.
- `RetireCnt`  out  32  count of non-bubble instructions committed.

## Operation
- **Destination and source decode** (opcode = `Instr[31:26]`, funct = `Instr[5:0]`):
  - R-type (000000) writes rd with `W_ALUAns`, except funct jr 001000, mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011, which write nothing.
  - R-type jalr (001001) writes rd with `W_PC+8`.
  - jal (000011) writes $31 with `W_PC+8`.
  - I-type ALU ops (001000, 001001, 001010, 001011, 001100, 001101, 001110, 001111) write rt with `W_ALUAns`.
  - Loads write rt with extracted data:
    - lw 100011: `W_DMRD`.
    - lb 100000 / lbu 100100: byte at `W_ALUAns[1:0]` (0 = bits 7:0), sign- or zero-extended.
    - lh 100001 / lhu 100101: halfword at `W_ALUAns[1]` (0 = bits 15:0), sign- or zero-extended.
  - All other opcodes (stores, branches, j, unknown): no write, `W_WA=0`.
- **Write outputs:**
  - `W_WA` = decoded destination, or 0 when there is no write.
  - `W_WE` = `(W_WA != 0)`.
  - `W_WD` = selected data when `W_WE`, else 0.
- **Register file:**
  - `$0` reads 0 always.
  - On a rising edge with `reset==1` and `W_WE`, `GRF[W_WA] <= W_WD`.
- **Read and bypass:**
  - `D_RDx` = 0 if `D_Ax==0`.
  - Else `W_WD` if `W_WE && W_WA==D_Ax`.
  - Else `GRF[D_Ax]`.
  - Both ports are independent; both may bypass at once.
- **Retire counter:**
  - Increments by 1 on each rising edge with `reset==1` and `W_Instr != 0`, including non-writing instructions.
  - Wraps 32'hFFFF_FFFF → 0.

## Timing
- **Reset:** all 31 registers and `RetireCnt` become 0 at the first rising edge with `reset==0`. Reset wins over a simultaneous write and increment.
- **Combinational outputs:** `W_WE`, `W_WA`, `W_WD`, `D_RD1`, `D_RD2` are combinational from inputs and state. They are not registered, so they have no reset value of their own. With `W_Instr=0`, they are 0 / 0 / 0 / the `GRF` value.
- **Write latency:** the value is architecturally visible through a `GRF` read one edge after it is presented. The bypass makes it visible to `D_RDx` in the same cycle (zero latency).
- **Bubbles:** back-to-back bubbles (flush/stall bubbles from the M/W register) perform no write and no count.
- **Writes to $0:** dropped; `W_WE=0` and the bypass is inhibited.

## Test plan
- **Reset:** hold `reset=0` for 2 edges after arbitrary writes, release → every `D_RDx` reads 0 and `RetireCnt=0`. Assert `reset=0` in the same cycle as an `ori $5` write → `$5` stays 0.
- **ALU write and bypass:** ori rt=5 (`W_Instr=32'h3405_1234`) with `W_ALUAns=32'h1234` and `D_A1=5`:
  - Same cycle: `D_RD1=32'h1234`, `W_WE=1`, `W_WA=5`.
  - After the edge, with a bubble in W: `D_RD1` still reads 32'h1234 from `GRF`.
- **Sub-word loads:** `W_DMRD=32'h80FF_7F01`.
  - lb with `W_ALUAns[1:0]=3` → 32'hFFFF_FF80.
  - lbu with offset 1 → 32'h0000_007F.
  - lh with offset 2 → 32'hFFFF_80FF.
  - lhu with offset 0 → 32'h0000_7F01.
- **Link writes:** jal with `W_PC=32'h0000_3008` → `$31=32'h0000_3010`. jalr rd=9 → `$9=W_PC+8`.
- **No-write cases:**
  - sw, beq, jr, and mult each yield `W_WE=0` and `GRF` unchanged, but `RetireCnt` increments once each.
  - addu with rd=0 yields `W_WE=0`, and `D_RD1` with `D_A1=0` stays 0.
- **Counter wrap and dual bypass:**
  - Force `RetireCnt` to 32'hFFFF_FFFF via 2^32−1 retirements (or a bench-level deposit), then retire one more → 0.
  - `D_A1=D_A2=W_WA=7` → both ports return `W_WD`.

Source files
------------

// File: rtl/wb_grf.sv
// Writeback stage and 32x32 general register file for the five-stage MIPS pipeline.
// Decodes the W-stage destination/data, commits to the GRF, and serves bypassed D-stage reads.
module wb_grf #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_Instr,
    input  logic [31:0] W_ALUAns,
    input  logic [31:0] W_DMRD,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    output logic [31:0] D_RD1,
    output logic [31:0] D_RD2,
    output logic        W_WE,
    output logic [4:0]  W_WA,
    output logic [31:0] W_WD,
    output logic [31:0] RetireCnt
);

    // RESET_PC is documentation only; the named block below just keeps the parameter referenced.
    if (RESET_PC[1:0] != 2'b00) begin : g_misaligned_reset_pc
    end

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_LINK,
        SRC_LOAD
    } wd_src_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  dest;
    wd_src_e     src;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] link_addr;
    logic [31:0] sel_data;

    logic [31:0] grf_q [32];
    logic [31:0] retire_q;
    logic [31:0] retire_d;

    assign opcode    = W_Instr[31:26];
    assign funct     = W_Instr[5:0];
    assign rt        = W_Instr[20:16];
    assign rd        = W_Instr[15:11];
    assign link_addr = W_PC + 32'd8;

    always_comb begin
        dest = 5'd0;
        src  = SRC_ALU;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b001000, 6'b011000, 6'b011001, 6'b011010,
                    6'b011011, 6'b010001, 6'b010011: dest = 5'd0;
                    6'b001001: begin
                        dest = rd;
                        src  = SRC_LINK;
                    end
                    default: dest = rd;
                endcase
            end
            6'b000011: begin
                dest = 5'd31;
                src  = SRC_LINK;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: dest = rt;
            6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: begin
                dest = rt;
                src  = SRC_LOAD;
            end
            default: dest = 5'd0;
        endcase
    end

    always_comb begin
        case (W_ALUAns[1:0])
            2'd0:    load_byte = W_DMRD[7:0];
            2'd1:    load_byte = W_DMRD[15:8];
            2'd2:    load_byte = W_DMRD[23:16];
            default: load_byte = W_DMRD[31:24];
        endcase
        load_half = W_ALUAns[1] ? W_DMRD[31:16] : W_DMRD[15:0];
        case (opcode)
            6'b100000: load_data = {{24{load_byte[7]}}, load_byte};
            6'b100100: load_data = {24'd0, load_byte};
            6'b100001: load_data = {{16{load_half[15]}}, load_half};
            6'b100101: load_data = {16'd0, load_half};
            default:   load_data = W_DMRD;
        endcase
    end

    always_comb begin
        case (src)
            SRC_LINK: sel_data = link_addr;
            SRC_LOAD: sel_data = load_data;
            default:  sel_data = W_ALUAns;
        endcase
    end

    assign W_WA = dest;
    assign W_WE = (dest != 5'd0);
    assign W_WD = W_WE ? sel_data : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_q[i] <= 32'd0;
            end
        end else if (W_WE) begin
            grf_q[W_WA] <= W_WD;
        end
    end

    // Bubbles are all-zero words; every other instruction retires, writing or not.
    assign retire_d = retire_q + {31'd0, (W_Instr != 32'd0)};

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_q <= 32'd0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign RetireCnt = retire_q;

    always_comb begin
        if (D_A1 == 5'd0) begin
            D_RD1 = 32'd0;
        end else if (W_WE && (W_WA == D_A1)) begin
            D_RD1 = W_WD;
        end else begin
            D_RD1 = grf_q[D_A1];
        end
        if (D_A2 == 5'd0) begin
            D_RD2 = 32'd0;
        end else if (W_WE && (W_WA == D_A2)) begin
            D_RD2 = W_WD;
        end else begin
            D_RD2 = grf_q[D_A2];
        end
    end

endmodule

// File: tb/tb_wb_grf.sv
// Randomized and directed bench for wb_grf against an array-based architectural model.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_PC, W_Instr, W_ALUAns, W_DMRD;
    logic [4:0]  D_A1, D_A2;
    logic [31:0] D_RD1, D_RD2, W_WD, RetireCnt;
    logic        W_WE;
    logic [4:0]  W_WA;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .W_PC      (W_PC),
        .W_Instr   (W_Instr),
        .W_ALUAns  (W_ALUAns),
        .W_DMRD    (W_DMRD),
        .D_A1      (D_A1),
        .D_A2      (D_A2),
        .D_RD1     (D_RD1),
        .D_RD2     (D_RD2),
        .W_WE      (W_WE),
        .W_WA      (W_WA),
        .W_WD      (W_WD),
        .RetireCnt (RetireCnt)
    );

    int          nvec = 0;
    int          nerr = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;

    // Architectural effect of one W-stage instruction: destination (0 = none) and data.
    function automatic void m_write(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] alu, input logic [31:0] dmrd,
                                    output logic [4:0] wa, output logic [31:0] wd);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sh;
        logic [15:0] h;
        op = instr[31:26];
        fn = instr[5:0];
        sh = dmrd >> (8 * alu[1:0]);
        h  = alu[1] ? dmrd[31:16] : dmrd[15:0];
        wa = 5'd0;
        wd = 32'd0;
        if (op == 6'd0) begin
            if (fn inside {6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13}) wa = 5'd0;
            else if (fn == 6'h09) begin wa = instr[15:11]; wd = pc + 32'd8; end
            else begin wa = instr[15:11]; wd = alu; end
        end else if (op == 6'd3) begin
            wa = 5'd31; wd = pc + 32'd8;
        end else if (op >= 6'd8 && op <= 6'd15) begin
            wa = instr[20:16]; wd = alu;
        end else if (op == 6'h23) begin
            wa = instr[20:16]; wd = dmrd;
        end else if (op == 6'h20) begin
            wa = instr[20:16]; wd = {{24{sh[7]}}, sh[7:0]};
        end else if (op == 6'h24) begin
            wa = instr[20:16]; wd = {24'd0, sh[7:0]};
        end else if (op == 6'h21) begin
            wa = instr[20:16]; wd = {{16{h[15]}}, h};
        end else if (op == 6'h25) begin
            wa = instr[20:16]; wd = {16'd0, h};
        end
        if (wa == 5'd0) wd = 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wa != 5'd0 && wa == a) return wd;
        return m_grf[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [4:0]  wa;
        logic [31:0] wd;
        m_write(W_Instr, W_PC, W_ALUAns, W_DMRD, wa, wd);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (wa != 5'd0) m_grf[wa] = wd;
            if (W_Instr != 32'd0) m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        logic [4:0]  wa;
        logic [31:0] wd;
        if (chk_en) begin
            m_write(W_Instr, W_PC, W_ALUAns, W_DMRD, wa, wd);
            check("model_we", {31'd0, W_WE}, {31'd0, (wa != 5'd0)});
            check("model_wa", {27'd0, W_WA}, {27'd0, wa});
            check("model_wd", W_WD, wd);
            check("model_rd1", D_RD1, m_read(D_A1, wa, wd));
            check("model_rd2", D_RD2, m_read(D_A2, wa, wd));
            check("model_cnt", RetireCnt, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] dmrd,
                          input logic [4:0] a1, input logic [4:0] a2);
        W_Instr = instr; W_PC = pc; W_ALUAns = alu; W_DMRD = dmrd; D_A1 = a1; D_A2 = a2;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rdv, input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, rdv, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rtv,
                                          input logic [15:0] imm);
        return {op, 5'd0, rtv, imm};
    endfunction

    localparam logic [31:0] DM = 32'h80FF_7F01;

    initial begin
        logic [5:0] ops [22];
        logic [5:0] fns [12];
        logic [31:0] instr;
        ops = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
                6'h0f, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2b, 6'h04, 6'h02, 6'h05, 6'h3f};
        fns = '{6'h21, 6'h23, 6'h08, 6'h09, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13, 6'h00, 6'h2a};

        reset = 1'b0;
        set_in(32'd0, 32'h3000, 32'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;

        set_in(32'h3405_1234, 32'h3000, 32'h1234, 32'd0, 5'd5, 5'd0);
        #1;
        check("ori_bypass_rd1", D_RD1, 32'h1234);
        check("ori_we", {31'd0, W_WE}, 32'd1);
        check("ori_wa", {27'd0, W_WA}, 32'd5);
        step(); set_in(32'd0, 32'h3004, 32'd0, 32'd0, 5'd5, 5'd0); #1;
        check("ori_grf_rd1", D_RD1, 32'h1234);

        step(); set_in(itype(6'h20, 5'd10, 16'd3), 32'h3008, 32'd3, DM, 5'd0, 5'd0); #1;
        check("lb_off3", W_WD, 32'hFFFF_FF80);
        step(); set_in(itype(6'h24, 5'd11, 16'd1), 32'h300c, 32'd1, DM, 5'd0, 5'd0); #1;
        check("lbu_off1", W_WD, 32'h0000_007F);
        step(); set_in(itype(6'h21, 5'd12, 16'd2), 32'h3010, 32'd2, DM, 5'd0, 5'd0); #1;
        check("lh_off2", W_WD, 32'hFFFF_80FF);
        step(); set_in(itype(6'h25, 5'd13, 16'd0), 32'h3014, 32'd0, DM, 5'd0, 5'd0); #1;
        check("lhu_off0", W_WD, 32'h0000_7F01);

        step(); set_in({6'h03, 26'h0000c10}, 32'h3008, 32'd0, 32'd0, 5'd0, 5'd0); #1;
        check("jal_wa", {27'd0, W_WA}, 32'd31);
        check("jal_wd", W_WD, 32'h0000_3010);
        step(); set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd31, 5'd13); #1;
        check("jal_grf", D_RD1, 32'h0000_3010);
        check("lhu_grf", D_RD2, 32'h0000_7F01);
        step(); set_in(rtype(5'd9, 6'h09), 32'h4000, 32'd0, 32'd0, 5'd0, 5'd0); #1;
        check("jalr_wd", W_WD, 32'h0000_4008);

        step(); set_in(itype(6'h2b, 5'd5, 16'd0), 32'h4004, 32'h99, 32'd0, 5'd0, 5'd0); #1;
        check("sw_we", {31'd0, W_WE}, 32'd0);
        step(); set_in({6'h04, 5'd5, 5'd5, 16'h0004}, 32'h4008, 32'h99, 32'd0, 5'd0, 5'd0); #1;
        check("beq_we", {31'd0, W_WE}, 32'd0);
        step(); set_in({6'd0, 5'd31, 5'd0, 5'd5, 5'd0, 6'h08}, 32'h400c, 32'h99, 32'd0, 5'd0, 5'd0); #1;
        check("jr_we", {31'd0, W_WE}, 32'd0);
        step(); set_in(rtype(5'd5, 6'h18), 32'h4010, 32'h99, 32'd0, 5'd0, 5'd0); #1;
        check("mult_we", {31'd0, W_WE}, 32'd0);
        step(); set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd5, 5'd9); #1;
        check("nowrite_grf5", D_RD1, 32'h1234);
        check("jalr_grf9", D_RD2, 32'h0000_4008);
        check("retire_11", RetireCnt, 32'd11);

        step(); set_in(rtype(5'd0, 6'h21), 32'h4014, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd0); #1;
        check("addu_r0_we", {31'd0, W_WE}, 32'd0);
        check("addu_r0_rd1", D_RD1, 32'd0);
        step(); set_in(rtype(5'd7, 6'h21), 32'h4018, 32'hCAFE_BABE, 32'd0, 5'd7, 5'd7); #1;
        check("dual_bypass_rd1", D_RD1, 32'hCAFE_BABE);
        check("dual_bypass_rd2", D_RD2, 32'hCAFE_BABE);

        step(); reset = 1'b0; set_in(itype(6'h0d, 5'd5, 16'h5555), 32'h401c, 32'h5555, 32'd0, 5'd0, 5'd0);
        step(); set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd0, 5'd0);
        step(); reset = 1'b1; set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd5, 5'd7); #1;
        check("reset_r5", D_RD1, 32'd0);
        check("reset_r7", D_RD2, 32'd0);
        check("reset_cnt", RetireCnt, 32'd0);

        step(); set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd0, 5'd0);
        force dut.retire_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_q;
        #1 check("cnt_preload", RetireCnt, 32'hFFFF_FFFF);
        step(); set_in(itype(6'h0d, 5'd1, 16'd1), 32'h5000, 32'd1, 32'd0, 5'd0, 5'd0);
        step(); set_in(32'd0, 32'h0, 32'd0, 32'd0, 5'd1, 5'd0); #1;
        check("cnt_wrap", RetireCnt, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 99) != 0);
            instr = $urandom;
            instr[31:26] = ops[$urandom_range(0, 21)];
            if (instr[31:26] == 6'd0) instr[5:0] = fns[$urandom_range(0, 11)];
            if ($urandom_range(0, 4) == 0) instr = 32'd0;
            W_Instr  = instr;
            W_PC     = {$urandom_range(0, 65535), 2'b00};
            W_ALUAns = $urandom;
            W_DMRD   = $urandom;
            case ($urandom_range(0, 3))
                0: D_A1 = instr[20:16];
                1: D_A1 = instr[15:11];
                2: D_A1 = 5'd31;
                default: D_A1 = 5'($urandom);
            endcase
            D_A2 = ($urandom_range(0, 1) == 0) ? D_A1 : 5'($urandom);
        end

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
